// File: rtl/vigna_mem_pkg.sv
// Shared definitions for the vigna bus memory responder: port FSM state
// encoding, the default out-of-range read pattern and the byte-lane merge.
package vigna_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } port_state_t;

  localparam logic [31:0] OOR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Replace each strobed byte lane of old_word with the matching lane of new_word.
  function automatic logic [31:0] merge(input logic [31:0] old_word,
                                        input logic [31:0] new_word,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vigna_bus_port.sv
// Latency FSM and request latch for one valid/ready port. The request
// fields are captured on acceptance; resp is high for the single response
// cycle, LATENCY cycles after acceptance. resp_next flags the edge that
// enters RESP so the owner can register response data on that edge.
module vigna_bus_port
  import vigna_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned FW      = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          valid,
  input  logic [FW-1:0] req,
  output logic          accept,
  output logic          resp,
  output logic          resp_next,
  output logic [FW-1:0] req_q
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  port_state_t   state_r;
  port_state_t   state_next_s;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_next_s;
  logic [FW-1:0] req_r;

  // Next-state and wait-counter logic for the IDLE/WAIT/RESP sequence.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (valid) begin
          cnt_next_s   = LAT_M1;
          state_next_s = (LATENCY > 1) ? WAIT : RESP;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_next_s = RESP;
        end else begin
          state_next_s = WAIT;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  assign accept    = (state_r == IDLE) && valid;
  assign resp      = (state_r == RESP);
  assign resp_next = (state_next_s == RESP);
  assign req_q     = req_r;

  // State and latency counter registers; reset returns the port to IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Capture the request fields on acceptance so later changes are ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_r <= {FW{1'b0}};
    end else if (accept) begin
      req_r <= req;
    end else begin
      req_r <= req_r;
    end
  end

endmodule

// File: rtl/vigna_bus_mem.sv
// Dual-port memory responder for the vigna instruction and data buses.
// Holds the RAM, address decode, access counters and the tohost halt
// register; each port's timing comes from a vigna_bus_port instance.
// Response data is registered on the edge entering RESP; a d-port write
// commits on the edge leaving RESP, so an i-port read in the same RESP
// cycle sees the old word, and a read entering RESP on that commit edge
// is forwarded the merged new word.
module vigna_bus_mem
  import vigna_mem_pkg::*;
#(
  parameter int unsigned MEM_AW      = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned I_LATENCY   = 1,
  parameter int unsigned D_LATENCY   = 1,
  parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0,
  parameter logic [31:0] OOR_DATA    = OOR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        halted,
  output logic [31:0] halt_code,
  output logic [31:0] i_count,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned DEPTH = 2 ** MEM_AW;
  localparam logic [32:0] SPAN  = 33'd4 << MEM_AW;

  logic [31:0] mem_r [DEPTH];

  logic              i_accept_s, i_resp_s, i_resp_next_s;
  logic [31:0]       i_addr_q_s, i_addr_e_s;
  logic              d_accept_s, d_resp_s, d_resp_next_s;
  logic [67:0]       d_req_q_s;
  logic [31:0]       d_addr_q_s, d_wdata_q_s, d_addr_e_s;
  logic [3:0]        d_wstrb_q_s, d_wstrb_e_s;
  logic              i_in_e_s, d_in_e_s, d_in_q_s;
  logic [MEM_AW-1:0] i_idx_e_s, d_idx_e_s, d_idx_q_s;
  logic              d_wr_e_s, d_wr_q_s, d_tohost_e_s, d_tohost_q_s;
  logic              d_commit_s, err_next_s;
  logic [31:0]       i_word_s, d_word_s;

  // True when the byte address falls inside the RAM window.
  function automatic logic in_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a - BASE_ADDR};
    return off < SPAN;
  endfunction

  vigna_bus_port #(.LATENCY(I_LATENCY), .FW(32)) u_i_port (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (i_valid),
    .req       (i_addr),
    .accept    (i_accept_s),
    .resp      (i_resp_s),
    .resp_next (i_resp_next_s),
    .req_q     (i_addr_q_s)
  );

  vigna_bus_port #(.LATENCY(D_LATENCY), .FW(68)) u_d_port (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (d_valid),
    .req       ({d_wstrb, d_wdata, d_addr}),
    .accept    (d_accept_s),
    .resp      (d_resp_s),
    .resp_next (d_resp_next_s),
    .req_q     (d_req_q_s)
  );

  assign d_addr_q_s  = d_req_q_s[31:0];
  assign d_wdata_q_s = d_req_q_s[63:32];
  assign d_wstrb_q_s = d_req_q_s[67:64];

  // Decode of the transaction entering RESP (raw fields when accepted this
  // edge, latched otherwise) and of the d-port transaction currently in RESP.
  always_comb begin
    i_addr_e_s    = i_accept_s ? i_addr : i_addr_q_s;
    d_addr_e_s    = d_accept_s ? d_addr : d_addr_q_s;
    d_wstrb_e_s   = d_accept_s ? d_wstrb : d_wstrb_q_s;
    i_in_e_s      = in_range(i_addr_e_s);
    d_in_e_s      = in_range(d_addr_e_s);
    d_in_q_s      = in_range(d_addr_q_s);
    i_idx_e_s     = i_addr_e_s[MEM_AW+1:2];
    d_idx_e_s     = d_addr_e_s[MEM_AW+1:2];
    d_idx_q_s     = d_addr_q_s[MEM_AW+1:2];
    d_wr_e_s      = (d_wstrb_e_s != 4'd0);
    d_wr_q_s      = (d_wstrb_q_s != 4'd0);
    d_tohost_e_s  = (d_addr_e_s == TOHOST_ADDR);
    d_tohost_q_s  = (d_addr_q_s == TOHOST_ADDR);
    d_commit_s    = d_resp_s && d_wr_q_s && d_in_q_s && !d_tohost_q_s;
    err_next_s    = (i_resp_next_s && !i_in_e_s) ||
                    (d_resp_next_s && !d_in_e_s && !(d_wr_e_s && d_tohost_e_s));
  end

  // Read words for both ports, forwarding a write that commits this edge.
  always_comb begin
    i_word_s = OOR_DATA;
    d_word_s = OOR_DATA;
    if (!i_in_e_s) begin
      i_word_s = OOR_DATA;
    end else if (d_commit_s && (d_idx_q_s == i_idx_e_s)) begin
      i_word_s = merge(mem_r[i_idx_e_s], d_wdata_q_s, d_wstrb_q_s);
    end else begin
      i_word_s = mem_r[i_idx_e_s];
    end
    if (d_in_e_s) begin
      d_word_s = mem_r[d_idx_e_s];
    end else begin
      d_word_s = OOR_DATA;
    end
  end

  // RAM write port: byte-strobed commit in the d-port RESP cycle; never reset.
  always_ff @(posedge clk) begin
    if (resetn && d_commit_s) begin
      mem_r[d_idx_q_s] <= merge(mem_r[d_idx_q_s], d_wdata_q_s, d_wstrb_q_s);
    end
  end

  // Registered responses, error pulse, counters and the tohost halt register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      i_ready   <= 1'b0;
      i_rdata   <= 32'd0;
      d_ready   <= 1'b0;
      d_rdata   <= 32'd0;
      err       <= 1'b0;
      halted    <= 1'b0;
      halt_code <= 32'd0;
      i_count   <= 32'd0;
      rd_count  <= 32'd0;
      wr_count  <= 32'd0;
    end else begin
      i_ready <= i_resp_next_s;
      i_rdata <= i_resp_next_s ? i_word_s : 32'd0;
      d_ready <= d_resp_next_s;
      d_rdata <= (d_resp_next_s && !d_wr_e_s) ? d_word_s : 32'd0;
      err     <= err_next_s;
      if (i_resp_s) begin
        i_count <= i_count + 32'd1;
      end
      if (d_resp_s && d_wr_q_s) begin
        wr_count <= wr_count + 32'd1;
      end
      if (d_resp_s && !d_wr_q_s) begin
        rd_count <= rd_count + 32'd1;
      end
      if (d_resp_s && d_wr_q_s && d_tohost_q_s) begin
        halted    <= 1'b1;
        halt_code <= d_wdata_q_s;
      end
    end
  end

endmodule

// File: doc/vigna_bus_mem.md
Name: vigna_bus_mem

Overview:
- Parametrised dual-port memory responder for the vigna core's instruction bus (i_*) and data bus (d_*), using the valid/ready protocol.
- Replaces the ad-hoc per-bench memory always-blocks: configurable depth, per-port wait states and byte-strobe writes.
- Adds out-of-range error flagging, access counters and a "tohost" halt register for self-checking benches.
- Sits beside the core in every simulation top and in the FPGA smoke build.

Parameters:
- MEM_AW, 6, word-address width; depth = 2**MEM_AW 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2**MEM_AW.
- I_LATENCY, 1, cycles from request acceptance to i_ready (1..15).
- D_LATENCY, 1, cycles from request acceptance to d_ready (1..15).
- TOHOST_ADDR, 32'hFFFF_FFF0, byte address of the halt register (outside the RAM range).
- OOR_DATA, 32'hDEAD_BEEF, read data returned for out-of-range addresses.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- i_valid  in  1  instruction request.
- i_addr  in  32  instruction byte address.
- i_ready  out  1  one-cycle response strobe.
- i_rdata  out  32  instruction word, valid while i_ready.
- d_valid  in  1  data request.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  byte enables; 0 = read.
- d_ready  out  1  one-cycle response strobe.
- d_rdata  out  32  load word, valid while d_ready.
- err  out  1  one-cycle pulse on any out-of-range access (either port).
- halted  out  1  sticky; set by a write to TOHOST_ADDR.
- halt_code  out  32  data of that write.
- i_count  out  32  completed i-port responses.
- rd_count  out  32  completed d-port reads.
- wr_count  out  32  completed d-port writes.

Behaviour:
- Reset (resetn=0 at posedge clk):
  - All outputs go to 0: i_ready, d_ready, i_rdata, d_rdata, err, halted, halt_code and all counters.
  - Both port FSMs go to IDLE.
  - RAM contents are not cleared.
  - Reset asserted mid-transaction aborts it: no write commits and no ready is issued.
- Per-port FSM (identical for both ports), states IDLE, WAIT, RESP:
  - IDLE: if valid is high, latch the address (and wdata/wstrb on the d-port), load lat_cnt = LATENCY-1, then go to WAIT if LATENCY>1, else RESP.
  - WAIT: decrement lat_cnt; go to RESP when lat_cnt==1.
  - RESP: ready=1 for exactly this cycle, rdata driven; then go to IDLE.
  - Ready is therefore high on cycle N after acceptance, where N = LATENCY.
- Handshake rules:
  - The requester holds valid and the request fields stable until ready.
  - Latched values are used, so field changes after acceptance are ignored.
  - The requester must drop valid, or present a new request, in the cycle after ready.
  - A valid seen in IDLE is always a new request; back-to-back throughput is one transaction per LATENCY+1 cycles.
  - Valid dropping before ready is a protocol violation; the transaction still completes.
- Address decode, on the latched address:
  - The word index is addr[MEM_AW+1:2].
  - An address is in range when (addr - BASE_ADDR) < 4*2**MEM_AW.
  - addr[1:0] is ignored.
- Read, either port: in the RESP cycle rdata = mem[index], or OOR_DATA with err=1 if the address is out of range.
- Write (d-port, wstrb != 0): committed in the RESP cycle. Each strobed byte lane k updates mem[index][8k+7:8k]; unstrobed lanes keep their value. d_rdata = 0 for writes.
  - TOHOST_ADDR: halted <= 1 and halt_code <= full d_wdata regardless of wstrb. RAM is not touched and err is not raised.
  - Any other out-of-range address: the write is dropped and err=1.
- Collision: if the i-port RESP reads the same word that the d-port RESP writes in the same cycle, i_rdata returns the old data (read-before-write). Two d-port writes cannot overlap.
- Counters:
  - Each increments by 1 in the RESP cycle of its port and type, out-of-range included.
  - They wrap modulo 2**32 and cannot saturate.
- halted is sticky until reset. Later TOHOST writes overwrite halt_code.

Decomposition:
- Shared package vigna_mem_pkg holds:
  - the port FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the OOR_DATA default;
  - a byte-lane merge function merge(old, new, strb).
- One sub-module, vigna_bus_port: the latency FSM and address latch. Parameter LATENCY; outputs accept and resp strobes. It is instantiated twice; the RAM array, decode, counters and tohost logic stay in the top.

Test Plan:
- I_LATENCY=D_LATENCY=1: preload mem[0]=32'h8000_0093; i_valid at 0x0 -> i_ready 1 cycle after acceptance with i_rdata=32'h8000_0093; i_count=1.
- D_LATENCY=3: write 32'h1122_3344 with wstrb=4'b0101 to 0x8, where the word was 0 -> d_ready exactly 3 cycles after acceptance; a readback of 0x8 returns 32'h0022_0044; wr_count=1, rd_count=1.
- Read 0x100 with MEM_AW=6 -> d_rdata=32'hDEAD_BEEF, err pulses 1 cycle. Write to 0x100 -> RAM is unchanged and err pulses.
- Write 32'h0000_0001 to 0xFFFF_FFF0 -> halted=1, halt_code=1, err stays 0. A second write of 32'h2 -> halt_code=2.
- Same-cycle RESP, i-port read of 0x4 (old value 32'hAAAA_AAAA) and d-port write of 32'h5555_5555 to 0x4 -> i_rdata=32'hAAAA_AAAA; the next i-port read returns 32'h5555_5555.
- Assert resetn=0 during WAIT of a D_LATENCY=4 write -> no d_ready, memory unchanged, all counters 0. After release the port accepts a new request from IDLE.
